// File: rtl/pk_vault_sequencer.sv
// pk_vault_sequencer: host command sequencer in front of the shared AES-128 core and slot RAM.
// Boots by zero-filling slots 0..max_q, then serves one STORE or FETCH at a time.
module pk_vault_sequencer #(
  parameter int unsigned AES_TIMEOUT = 64,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] max_address,
  output logic              boot_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [127:0]      cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_data,
  output logic              rsp_err,
  output logic              aes_go,
  output logic [127:0]      aes_data_in,
  input  logic              aes_done,
  input  logic [127:0]      aes_data_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata
);

  localparam int unsigned     TmoW    = $clog2(AES_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(AES_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StBoot, StIdle, StEncWait, StWrite, StRdAddr, StRdCap, StResp
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   max_q;
  logic [ADDR_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic                boot_done_q, boot_done_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [127:0]        data_q, data_d;
  // Holds the ciphertext from capture through the RAM write and the response.
  logic [127:0]        rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  // State register; max_address is only sampled while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      max_q       <= max_address;
      boot_cnt_q  <= '0;
      boot_done_q <= 1'b0;
      tmo_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_done_q <= boot_done_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    boot_done_d = boot_done_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    aes_go      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StBoot: begin
        // Held in reset the write is suppressed so every output reads 0.
        mem_we   = ~rst;
        mem_addr = boot_cnt_q;
        // Terminal compare keeps max_q = all-ones from wrapping the counter.
        if (boot_cnt_q == max_q) begin
          state_d     = StIdle;
          boot_done_d = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        cmd_ready = boot_done_q;
        if (cmd_valid && boot_done_q) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          tmo_d  = '0;
          if (cmd_addr > max_q) begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else if (cmd_op) begin
            state_d = StRdAddr;
          end else begin
            state_d = StEncWait;
          end
        end
      end
      StEncWait: begin
        aes_go = (tmo_q == '0);
        tmo_d  = tmo_q + 1'b1;
        // Done is checked first so it wins over a coincident timeout.
        if (aes_done) begin
          state_d    = StWrite;
          rsp_data_d = aes_data_out;
          rsp_err_d  = 1'b0;
        end else if (tmo_q == TmoLast) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = rsp_data_q;
        state_d   = StResp;
      end
      StRdAddr: begin
        mem_addr = addr_q;
        state_d  = StRdCap;
      end
      StRdCap: begin
        rsp_data_d = mem_rdata;
        rsp_err_d  = 1'b0;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StBoot;
    endcase
  end

  assign boot_done   = boot_done_q;
  assign aes_data_in = data_q;
  assign rsp_data    = rsp_valid ? rsp_data_q : '0;
  assign rsp_err     = rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_pk_vault_sequencer.sv
// Bench for pk_vault_sequencer: directed scenarios plus random host traffic checked against
// a slot-level model (array of slot contents, expected latency from the command rules).
module tb_pk_vault_sequencer;

  localparam int unsigned  AesTimeout = 64;
  localparam int unsigned  AddrW      = 4;
  localparam logic [127:0] PtKnown    = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] CtKnown    = 128'h29C3505F571420F6402299B31A02D73A;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AddrW-1:0] max_address = '0;
  logic             boot_done, cmd_ready, rsp_valid, rsp_err, aes_go, mem_we;
  logic             cmd_valid = 1'b0, cmd_op = 1'b0, rsp_ready = 1'b0, aes_done = 1'b0;
  logic [AddrW-1:0] cmd_addr = '0, mem_addr;
  logic [127:0]     cmd_data = '0, aes_data_out = '0;
  logic [127:0]     rsp_data, aes_data_in, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pk_vault_sequencer #(.AES_TIMEOUT(AesTimeout), .ADDR_W(AddrW)) dut (
    .clk(clk), .rst(rst), .max_address(max_address), .boot_done(boot_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .aes_go(aes_go), .aes_data_in(aes_data_in), .aes_done(aes_done),
    .aes_data_out(aes_data_out), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Slot RAM with synchronous read.
  logic [127:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Bus monitor: cycle stamps of aes_go pulses and every RAM write.
  int               cyc = 0, go_cnt = 0, last_go = -1, wr_n = 0;
  int               wr_cyc  [1024];
  logic [AddrW-1:0] wr_addr [1024];
  logic [127:0]     wr_data [1024];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aes_go) begin
      go_cnt  <= go_cnt + 1;
      last_go <= cyc;
    end
    if (mem_we && wr_n < 1024) begin
      wr_cyc[wr_n]  <= cyc;
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_n          <= wr_n + 1;
    end
  end

  // Reference model: slot contents and the latched range limit.
  logic [127:0] ref_slot [16];
  int           ref_max = 0;

  // Reset with max_address = m; z packs all outputs one cycle into reset, k counts cycles from
  // release until boot_done, w0 is the write-log index at release.
  task automatic do_reset(input int m, output logic [9:0] z, output int k, output int w0);
    rst = 1'b1; max_address = AddrW'(m);
    cmd_valid = 1'b0; rsp_ready = 1'b0; aes_done = 1'b0;
    @(negedge clk);
    z = {boot_done, cmd_ready, rsp_valid, rsp_err, aes_go, mem_we,
         |mem_addr, |mem_wdata, |rsp_data, |aes_data_in};
    @(negedge clk);
    w0 = wr_n;
    rst = 1'b0;
    max_address = AddrW'($urandom);
    k = 0;
    while (!boot_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i <= m; i++) ref_slot[i] = '0;
    ref_max = m;
  endtask

  // Issue one command and play the AES core (done `lat` cycles after go; lat<0 never).
  task automatic do_cmd(input bit op, input int addr, input logic [127:0] pt, input int lat,
                        input logic [127:0] ct, input int hold,
                        output logic [127:0] r_data, output logic r_err, output int r_lat,
                        output int n_go, output int n_we, output logic [127:0] r_ain,
                        output bit r_acc, output bit r_stable, output bit r_back);
    int k, g, go0, we0;
    go0 = go_cnt; we0 = wr_n; g = -1; r_ain = '0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = AddrW'(addr); cmd_data = pt;
    r_acc = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = AddrW'($urandom);
    cmd_data  = {$urandom, $urandom, $urandom, $urandom};
    max_address = AddrW'($urandom);
    k = 1;
    while (!rsp_valid && k < 300) begin
      if (aes_go && g < 0) begin
        g = k;
        r_ain = aes_data_in;
      end
      aes_done = (g >= 0 && lat >= 0 && k == g + lat);
      aes_data_out = aes_done ? ct : ~ct;
      @(negedge clk);
      k++;
    end
    aes_done = 1'b0;
    r_lat = rsp_valid ? k : -1;
    r_data = rsp_data; r_err = rsp_err; r_stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== r_data || rsp_err !== r_err || cmd_ready !== 1'b0)
        r_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    r_back = cmd_ready;
    n_go = go_cnt - go0;
    n_we = wr_n - we0;
  endtask

  task automatic test_reset();
    logic [9:0] z; int k, w0;
    do_reset(1, z, k, w0);
    vectors++; if (z !== '0) begin miscompares++;
      $display("FAIL reset_outputs: got %b want 0", z); end
    vectors++; if (wr_n - w0 !== 2) begin miscompares++;
      $display("FAIL boot_write_count: got %0d want 2", wr_n - w0); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (wr_addr[w0+i] !== AddrW'(i) || wr_data[w0+i] !== '0) begin miscompares++;
        $display("FAIL boot_write_%0d: got addr %0d data %h want addr %0d data 0",
                 i, wr_addr[w0+i], wr_data[w0+i], i); end
    end
    vectors++; if (wr_cyc[w0+1] !== wr_cyc[w0] + 1) begin miscompares++;
      $display("FAIL boot_back_to_back: got gap %0d want 1", wr_cyc[w0+1] - wr_cyc[w0]); end
    vectors++; if (k !== 2) begin miscompares++;
      $display("FAIL boot_done_latency: got %0d want 2", k); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
      $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_store_known();
    logic [127:0] d, ain; logic e; int l, ng, nw; bit acc, st, back;
    do_cmd(1'b0, 1, PtKnown, 10, CtKnown, 0, d, e, l, ng, nw, ain, acc, st, back);
    ref_slot[1] = CtKnown;
    vectors++; if (acc !== 1'b1) begin miscompares++;
      $display("FAIL store_accept: got cmd_ready %b want 1", acc); end
    vectors++; if (d !== CtKnown || e !== 1'b0) begin miscompares++;
      $display("FAIL store_rsp: got %h err %b want %h err 0", d, e, CtKnown); end
    vectors++; if (l !== 13) begin miscompares++;
      $display("FAIL store_latency: got %0d want 13", l); end
    vectors++; if (ng !== 1) begin miscompares++;
      $display("FAIL store_go_count: got %0d want 1", ng); end
    vectors++; if (ain !== PtKnown) begin miscompares++;
      $display("FAIL store_aes_in: got %h want %h", ain, PtKnown); end
    vectors++;
    if (nw !== 1 || wr_addr[wr_n-1] !== AddrW'(1) || wr_data[wr_n-1] !== CtKnown) begin
      miscompares++;
      $display("FAIL store_write: got %0d writes addr %0d data %h want 1 write addr 1 data %h",
               nw, wr_addr[wr_n-1], wr_data[wr_n-1], CtKnown); end
    vectors++; if (wr_cyc[wr_n-1] !== last_go + 11) begin miscompares++;
      $display("FAIL store_write_cycle: got go+%0d want go+11", wr_cyc[wr_n-1] - last_go); end
    vectors++; if (back !== 1'b1) begin miscompares++;
      $display("FAIL store_ready_after: got %b want 1", back); end
  endtask

  task automatic test_fetch_hold();
    logic [127:0] d, ain; logic e; int l, ng, nw; bit acc, st, back;
    do_cmd(1'b1, 1, '0, -1, '0, 5, d, e, l, ng, nw, ain, acc, st, back);
    vectors++; if (l !== 3) begin miscompares++;
      $display("FAIL fetch_latency: got %0d want 3", l); end
    vectors++; if (d !== CtKnown || e !== 1'b0) begin miscompares++;
      $display("FAIL fetch_rsp: got %h err %b want %h err 0", d, e, CtKnown); end
    vectors++; if (st !== 1'b1) begin miscompares++;
      $display("FAIL fetch_hold_stable: got %b want 1", st); end
    vectors++; if (ng !== 0 || nw !== 0) begin miscompares++;
      $display("FAIL fetch_side_effects: got go %0d we %0d want 0 0", ng, nw); end
  endtask

  task automatic test_bad_addr();
    logic [127:0] d, ain; logic e; int l, ng, nw; bit acc, st, back;
    do_cmd(1'b0, 3, PtKnown, 5, CtKnown, 0, d, e, l, ng, nw, ain, acc, st, back);
    vectors++; if (d !== '0 || e !== 1'b1) begin miscompares++;
      $display("FAIL bad_addr_rsp: got %h err %b want 0 err 1", d, e); end
    vectors++; if (l !== 1) begin miscompares++;
      $display("FAIL bad_addr_latency: got %0d want 1", l); end
    vectors++; if (ng !== 0 || nw !== 0) begin miscompares++;
      $display("FAIL bad_addr_side_effects: got go %0d we %0d want 0 0", ng, nw); end
  endtask

  task automatic test_timeout();
    logic [127:0] d, ain, ct; logic e; int l, ng, nw, w; bit acc, st, back;
    do_cmd(1'b0, 0, PtKnown, -1, CtKnown, 0, d, e, l, ng, nw, ain, acc, st, back);
    vectors++; if (d !== '0 || e !== 1'b1) begin miscompares++;
      $display("FAIL timeout_rsp: got %h err %b want 0 err 1", d, e); end
    vectors++; if (l !== 1 + AesTimeout) begin miscompares++;
      $display("FAIL timeout_latency: got %0d want %0d", l, 1 + AesTimeout); end
    vectors++; if (ng !== 1 || nw !== 0) begin miscompares++;
      $display("FAIL timeout_side_effects: got go %0d we %0d want 1 0", ng, nw); end
    w = wr_n;
    aes_done = 1'b1; aes_data_out = CtKnown;
    @(negedge clk);
    aes_done = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wr_n !== w) begin miscompares++;
      $display("FAIL spurious_done: got ready %b rsp %b writes %0d want 1 0 0",
               cmd_ready, rsp_valid, wr_n - w); end
    do_cmd(1'b1, 0, '0, -1, '0, 0, d, e, l, ng, nw, ain, acc, st, back);
    vectors++; if (d !== ref_slot[0] || e !== 1'b0) begin miscompares++;
      $display("FAIL timeout_slot_unchanged: got %h err %b want %h", d, e, ref_slot[0]); end
    // Done in the last cycle of the window must beat the timeout.
    ct = {$urandom, $urandom, $urandom, $urandom};
    do_cmd(1'b0, 0, PtKnown, AesTimeout - 1, ct, 0, d, e, l, ng, nw, ain, acc, st, back);
    ref_slot[0] = ct;
    vectors++; if (d !== ct || e !== 1'b0 || l !== AesTimeout + 2) begin miscompares++;
      $display("FAIL done_wins: got %h err %b lat %0d want %h err 0 lat %0d",
               d, e, l, ct, AesTimeout + 2); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d, ain, ct; logic e; logic [9:0] z; int l, ng, nw, k, w0, g0, bad;
    bit acc, st, back;
    do_reset(15, z, k, w0);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (wr_addr[w0+i] !== AddrW'(i) || wr_data[w0+i] !== '0) bad++;
    vectors++; if (wr_n - w0 !== 16 || bad !== 0 || k !== 16) begin miscompares++;
      $display("FAIL full_boot: got %0d writes %0d bad latency %0d want 16 0 16",
               wr_n - w0, bad, k); end
    ct = {$urandom, $urandom, $urandom, $urandom};
    do_cmd(1'b0, 2, PtKnown, 3, ct, 0, d, e, l, ng, nw, ain, acc, st, back);
    ref_slot[2] = ct;
    vectors++; if (d !== ct || l !== 6) begin miscompares++;
      $display("FAIL pre_reset_store: got %h lat %0d want %h lat 6", d, l, ct); end
    g0 = go_cnt;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 4'd2; cmd_data = PtKnown;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (go_cnt - g0 !== 1 || rsp_valid !== 1'b0) begin miscompares++;
      $display("FAIL enc_wait_entry: got go %0d rsp %b want 1 0", go_cnt - g0, rsp_valid); end
    do_reset(15, z, k, w0);
    vectors++; if (z !== '0) begin miscompares++;
      $display("FAIL mid_reset_outputs: got %b want 0", z); end
    vectors++; if (wr_n - w0 !== 16 || k !== 16) begin miscompares++;
      $display("FAIL reboot: got %0d writes latency %0d want 16 16", wr_n - w0, k); end
    do_cmd(1'b1, 2, '0, -1, '0, 0, d, e, l, ng, nw, ain, acc, st, back);
    vectors++; if (d !== '0 || e !== 1'b0) begin miscompares++;
      $display("FAIL slot_cleared: got %h err %b want 0 err 0", d, e); end
  endtask

  task automatic test_random();
    logic [127:0] d, ain, ct, pt, exp_d; logic e, exp_e; logic [9:0] z;
    int l, ng, nw, k, w0, m, addr, lat, hold, exp_l, exp_we; bit op, acc, st, back;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        m = $urandom_range(0, 15);
        do_reset(m, z, k, w0);
        vectors++; if (k !== m + 1 || wr_n - w0 !== m + 1 || z !== '0) begin miscompares++;
          $display("FAIL rand_boot: got latency %0d writes %0d outs %b want %0d %0d 0",
                   k, wr_n - w0, z, m + 1, m + 1); end
      end
      op   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 15);
      lat  = ($urandom_range(0, 3) == 0) ? $urandom_range(AesTimeout - 2, AesTimeout + 2)
                                         : $urandom_range(0, 8);
      hold = $urandom_range(0, 3);
      pt   = {$urandom, $urandom, $urandom, $urandom};
      ct   = {$urandom, $urandom, $urandom, $urandom};
      exp_we = 0;
      if (addr > ref_max) begin
        exp_d = '0; exp_e = 1'b1; exp_l = 1;
      end else if (op) begin
        exp_d = ref_slot[addr]; exp_e = 1'b0; exp_l = 3;
      end else if (lat < int'(AesTimeout)) begin
        exp_d = ct; exp_e = 1'b0; exp_l = lat + 3; exp_we = 1;
        ref_slot[addr] = ct;
      end else begin
        exp_d = '0; exp_e = 1'b1; exp_l = AesTimeout + 1;
      end
      do_cmd(op, addr, pt, lat, ct, hold, d, e, l, ng, nw, ain, acc, st, back);
      vectors++; if (d !== exp_d || e !== exp_e) begin miscompares++;
        $display("FAIL rand_rsp[%0d]: got %h err %b want %h err %b", n, d, e, exp_d, exp_e); end
      vectors++; if (l !== exp_l || nw !== exp_we) begin miscompares++;
        $display("FAIL rand_timing[%0d]: got lat %0d we %0d want lat %0d we %0d",
                 n, l, nw, exp_l, exp_we); end
      vectors++; if (st !== 1'b1 || back !== 1'b1) begin miscompares++;
        $display("FAIL rand_handshake[%0d]: got stable %b ready %b want 1 1", n, st, back); end
    end
  endtask

  initial begin
    test_reset();
    test_store_known();
    test_fetch_hold();
    test_bad_addr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pk_vault_sequencer.md
Name: pk_vault_sequencer

Overview:
- Command sequencer between the host interface and the shared AES-128 encrypt core plus the 16-entry password slot RAM.
- After reset, boots by zero-filling slots 0..max_address, then raises boot_done.
- STORE: runs the plaintext password through the AES core (go/done handshake) and writes the ciphertext to a slot.
- FETCH: reads a slot's ciphertext back. One command in flight at a time; bounded-wait protection on the AES core.

Parameters:
- AES_TIMEOUT, 64, max cycles from aes_go to aes_done before the command is aborted with error.
- ADDR_W, 4, slot address width; RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- max_address  in  ADDR_W  highest valid slot; sampled on every cycle rst=1, ignored otherwise.
- boot_done  out  1  high once zero-fill completes; sticky until rst.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with boot_done=1.
- cmd_op  in  1  0=STORE, 1=FETCH.
- cmd_addr  in  ADDR_W  target slot.
- cmd_data  in  128  plaintext password (STORE only).
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response accept.
- rsp_data  out  128  ciphertext (STORE result or FETCH data).
- rsp_err  out  1  1 = address out of range or AES timeout.
- aes_go  out  1  one-cycle start pulse to the AES core.
- aes_data_in  out  128  plaintext to the core; stable from aes_go until done or abort.
- aes_done  in  1  core completion pulse.
- aes_data_out  in  128  ciphertext; valid in the cycle aes_done=1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  128  RAM write data.
- mem_rdata  in  128  synchronous-read data, valid one cycle after mem_addr.

Behaviour:
- Reset values: all outputs 0, state BOOT, boot counter 0, timeout counter 0; response register cleared. max_address latched into max_q.
- States: BOOT, IDLE, ENC_WAIT, WRITE, RD_ADDR, RD_CAP, RESP.
- BOOT: one write per cycle, mem_we=1, mem_wdata=0, mem_addr=0..max_q ascending.
  - The cycle after the write to max_q: boot_done=1, go to IDLE.
  - Fill takes exactly max_q+1 cycles; max_q=15 writes all slots without counter overflow (terminal compare, not wrap).
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready (cycle T); latch op, addr, data.
  - cmd_addr > max_q: T+1 enter RESP with rsp_err=1, rsp_data=0. No aes_go, no mem access.
  - Valid STORE: aes_go=1 at T+1 only; aes_data_in=latched data; enter ENC_WAIT.
  - Valid FETCH: mem_addr=addr at T+1 (RD_ADDR).
- ENC_WAIT: timeout counter increments each cycle.
  - aes_done=1 at cycle D: capture aes_data_out, go to WRITE.
  - No aes_done within AES_TIMEOUT cycles of aes_go: enter RESP with rsp_err=1, rsp_data=0. No RAM write.
  - If aes_done and the timeout coincide, done wins.
- WRITE (D+1): mem_we=1, mem_addr=addr, mem_wdata=captured ciphertext. D+2: RESP, rsp_data=ciphertext, rsp_err=0.
- RD_ADDR (T+1) → RD_CAP (T+2): capture mem_rdata → RESP at T+3.
- RESP: rsp_valid=1 with data/err stable until rsp_valid&&rsp_ready. The accept cycle returns to IDLE; cmd_ready=1 the following cycle (no same-cycle back-to-back).
- aes_done outside ENC_WAIT is ignored. mem_we is never 1 outside BOOT and WRITE.
- cmd_valid while cmd_ready=0 is not accepted; the requester holds it.
- rst mid-operation: aborts immediately; pending response discarded; boot_done drops; zero-fill reruns with the newly sampled max_address.

Test Plan:
- Boot, max_address=1 → mem_we high 2 cycles, addr 0 then 1, wdata 0; boot_done rises the next cycle; cmd_ready=1.
- STORE addr=1, data=128'h54776F204F6E65204E696E652054776F; model core returns 128'h29C3505F571420F6402299B31A02D73A after 10 cycles → one aes_go pulse; mem write at slot 1 one cycle after done; rsp_valid with that ciphertext, rsp_err=0.
- FETCH addr=1 after the previous store → rsp_valid at T+3, rsp_data=128'h29C3505F571420F6402299B31A02D73A. Hold rsp_ready low 5 cycles → data stable, cmd_ready stays 0.
- STORE addr=3 with max_address=1 → rsp_err=1, rsp_data=0, no aes_go, no mem_we.
- STORE with core never asserting done → rsp_err=1 exactly AES_TIMEOUT cycles after aes_go; slot unchanged; a spurious aes_done afterwards is ignored.
- Assert rst during ENC_WAIT → next cycle all outputs 0; after release, zero-fill reruns and the slot previously written reads back 0.
